// File: rtl/alu_share_arbiter.sv
// Purpose : round-robin share of one combinational alu between execute (req 0) and branch/addr unit (req 1).
// Latency : grant at N -> operands on o_a_* at N+1 -> response at N+2 when done returns immediately.
// Backpres: one op in flight; requesters see ready only in IDLE, response held until i_rsp_ready.
//
// Ports:
//   i_clk, i_rst               clock (rising edge), async active-low reset
//   i_rK_valid / o_rK_ready    request handshake for requester K (0,1)
//   i_rK_rs/rt/imm/funct/alu_src/pc  request operands
//   o_a_*                      operands toward the alu, non-zero only while executing
//   i_alu_value/pc/done        alu result
//   o_rsp_*                    tagged response channel (valid/ready, id, value, pc, err)
module alu_share_arbiter #(
    parameter int DWIDTH    = 32,
    parameter int IMM_WIDTH = 16,
    parameter int PC_WIDTH  = 32,
    parameter int FWIDTH    = 5,
    parameter int MAX_WAIT  = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_r0_valid,
    output logic                 o_r0_ready,
    input  logic [DWIDTH-1:0]    i_r0_rs,
    input  logic [DWIDTH-1:0]    i_r0_rt,
    input  logic [IMM_WIDTH-1:0] i_r0_imm,
    input  logic [FWIDTH-1:0]    i_r0_funct,
    input  logic                 i_r0_alu_src,
    input  logic [PC_WIDTH-1:0]  i_r0_pc,
    input  logic                 i_r1_valid,
    output logic                 o_r1_ready,
    input  logic [DWIDTH-1:0]    i_r1_rs,
    input  logic [DWIDTH-1:0]    i_r1_rt,
    input  logic [IMM_WIDTH-1:0] i_r1_imm,
    input  logic [FWIDTH-1:0]    i_r1_funct,
    input  logic                 i_r1_alu_src,
    input  logic [PC_WIDTH-1:0]  i_r1_pc,
    output logic [DWIDTH-1:0]    o_a_rs,
    output logic [DWIDTH-1:0]    o_a_rt,
    output logic [IMM_WIDTH-1:0] o_a_imm,
    output logic [FWIDTH-1:0]    o_a_funct,
    output logic                 o_a_alu_src,
    output logic [PC_WIDTH-1:0]  o_a_pc,
    input  logic [DWIDTH-1:0]    i_alu_value,
    input  logic [PC_WIDTH-1:0]  i_alu_pc,
    input  logic                 i_alu_done,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic                 o_rsp_id,
    output logic [DWIDTH-1:0]    o_rsp_value,
    output logic [PC_WIDTH-1:0]  o_rsp_pc,
    output logic                 o_rsp_err
);

    localparam int CW = $clog2(MAX_WAIT) + 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                 state, state_nxt;
    logic                   rr;
    logic [CW-1:0]          wait_cnt;
    logic                   gnt_vld, gnt_id;
    logic                   exec_done, exec_timeout;

    logic                   lat_id;
    logic [DWIDTH-1:0]      lat_rs, lat_rt;
    logic [IMM_WIDTH-1:0]   lat_imm;
    logic [FWIDTH-1:0]      lat_funct;
    logic                   lat_src;
    logic [PC_WIDTH-1:0]    lat_pc;
    logic [DWIDTH-1:0]      rsp_value;
    logic [PC_WIDTH-1:0]    rsp_pc;
    logic                   rsp_err;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        gnt_vld      = 1'b0;
        gnt_id       = 1'b0;
        o_r0_ready   = 1'b0;
        o_r1_ready   = 1'b0;
        o_rsp_valid  = 1'b0;
        exec_done    = 1'b0;
        exec_timeout = 1'b0;
        case (state)
            IDLE: begin
                // Reset gating keeps ready low while reset is held even though state reads IDLE.
                if (i_rst && (i_r0_valid || i_r1_valid)) begin
                    gnt_vld    = 1'b1;
                    gnt_id     = (i_r0_valid && i_r1_valid) ? rr : i_r1_valid;
                    o_r0_ready = ~gnt_id;
                    o_r1_ready = gnt_id;
                    state_nxt  = EXEC;
                end
            end
            EXEC: begin
                if (i_alu_done) begin
                    exec_done = 1'b1;
                    state_nxt = RESP;
                end else if (wait_cnt == CW'(MAX_WAIT - 1)) begin
                    exec_timeout = 1'b1;
                    state_nxt    = RESP;
                end
            end
            RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rr        <= 1'b0;
            wait_cnt  <= '0;
            lat_id    <= 1'b0;
            lat_rs    <= '0;
            lat_rt    <= '0;
            lat_imm   <= '0;
            lat_funct <= '0;
            lat_src   <= 1'b0;
            lat_pc    <= '0;
            rsp_value <= '0;
            rsp_pc    <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (gnt_vld) begin
                wait_cnt  <= '0;
                lat_id    <= gnt_id;
                lat_rs    <= gnt_id ? i_r1_rs      : i_r0_rs;
                lat_rt    <= gnt_id ? i_r1_rt      : i_r0_rt;
                lat_imm   <= gnt_id ? i_r1_imm     : i_r0_imm;
                lat_funct <= gnt_id ? i_r1_funct   : i_r0_funct;
                lat_src   <= gnt_id ? i_r1_alu_src : i_r0_alu_src;
                lat_pc    <= gnt_id ? i_r1_pc      : i_r0_pc;
            end
            // Counter leaves EXEC at MAX_WAIT-1 at the latest, so it never wraps.
            if (state == EXEC) wait_cnt <= wait_cnt + 1'b1;
            if (exec_done) begin
                rsp_value <= i_alu_value;
                rsp_pc    <= i_alu_pc;
                rsp_err   <= 1'b0;
            end else if (exec_timeout) begin
                rsp_value <= '0;
                rsp_pc    <= '0;
                rsp_err   <= 1'b1;
            end
            // Favour the other requester once this one's response is consumed.
            if (state == RESP && i_rsp_ready) rr <= ~lat_id;
        end
    end

    assign o_a_rs      = (state == EXEC) ? lat_rs    : '0;
    assign o_a_rt      = (state == EXEC) ? lat_rt    : '0;
    assign o_a_imm     = (state == EXEC) ? lat_imm   : '0;
    assign o_a_funct   = (state == EXEC) ? lat_funct : '0;
    assign o_a_alu_src = (state == EXEC) && lat_src;
    assign o_a_pc      = (state == EXEC) ? lat_pc    : '0;

    assign o_rsp_id    = (state == RESP) && lat_id;
    assign o_rsp_value = (state == RESP) ? rsp_value : '0;
    assign o_rsp_pc    = (state == RESP) ? rsp_pc    : '0;
    assign o_rsp_err   = (state == RESP) && rsp_err;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

    localparam int MAX_WAIT = 4;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_r0_valid, i_r1_valid;
    logic        o_r0_ready, o_r1_ready;
    logic [31:0] q_rs  [2];
    logic [31:0] q_rt  [2];
    logic [15:0] q_imm [2];
    logic [4:0]  q_fn  [2];
    logic        q_src [2];
    logic [31:0] q_pc  [2];
    logic [31:0] o_a_rs, o_a_rt, o_a_pc;
    logic [15:0] o_a_imm;
    logic [4:0]  o_a_funct;
    logic        o_a_alu_src;
    logic [31:0] i_alu_value, i_alu_pc;
    logic        i_alu_done;
    logic        o_rsp_valid, i_rsp_ready, o_rsp_id, o_rsp_err;
    logic [31:0] o_rsp_value, o_rsp_pc;

    int checks = 0;
    int errors = 0;
    logic model_rr = 1'b0;

    always #5 i_clk = ~i_clk;

    alu_share_arbiter #(.DWIDTH(32), .IMM_WIDTH(16), .PC_WIDTH(32), .FWIDTH(5), .MAX_WAIT(MAX_WAIT)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_r0_valid(i_r0_valid), .o_r0_ready(o_r0_ready),
        .i_r0_rs(q_rs[0]), .i_r0_rt(q_rt[0]), .i_r0_imm(q_imm[0]), .i_r0_funct(q_fn[0]),
        .i_r0_alu_src(q_src[0]), .i_r0_pc(q_pc[0]),
        .i_r1_valid(i_r1_valid), .o_r1_ready(o_r1_ready),
        .i_r1_rs(q_rs[1]), .i_r1_rt(q_rt[1]), .i_r1_imm(q_imm[1]), .i_r1_funct(q_fn[1]),
        .i_r1_alu_src(q_src[1]), .i_r1_pc(q_pc[1]),
        .o_a_rs(o_a_rs), .o_a_rt(o_a_rt), .o_a_imm(o_a_imm), .o_a_funct(o_a_funct),
        .o_a_alu_src(o_a_alu_src), .o_a_pc(o_a_pc),
        .i_alu_value(i_alu_value), .i_alu_pc(i_alu_pc), .i_alu_done(i_alu_done),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_id(o_rsp_id),
        .o_rsp_value(o_rsp_value), .o_rsp_pc(o_rsp_pc), .o_rsp_err(o_rsp_err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ready0"}, o_r0_ready, 0);
        chk({tag, "_ready1"}, o_r1_ready, 0);
        chk({tag, "_rsp_valid"}, o_rsp_valid, 0);
        chk({tag, "_a_rs"}, o_a_rs, 0);
        chk({tag, "_a_pc"}, o_a_pc, 0);
        chk({tag, "_rsp_value"}, o_rsp_value, 0);
        chk({tag, "_rsp_err"}, o_rsp_err, 0);
    endtask

    // One full transaction: grant, d-th exec cycle brings done (d > MAX_WAIT never does),
    // w cycles of response backpressure, then the handshake.
    task automatic do_op(input logic v0, input logic v1, input int d, input int w,
                         input logic [31:0] aval, input logic [31:0] apc,
                         input logic eid, input logic eerr,
                         input logic [31:0] evl, input logic [31:0] epc);
        @(negedge i_clk);
        i_r0_valid = v0;
        i_r1_valid = v1;
        #1;
        chk("grant_ready0", o_r0_ready, eid == 1'b0);
        chk("grant_ready1", o_r1_ready, eid == 1'b1);
        chk("grant_rsp_valid", o_rsp_valid, 0);
        for (int c = 1; c <= MAX_WAIT; c++) begin
            @(negedge i_clk);
            chk("exec_a_rs", o_a_rs, q_rs[eid]);
            chk("exec_a_rt", o_a_rt, q_rt[eid]);
            chk("exec_a_imm", o_a_imm, q_imm[eid]);
            chk("exec_a_funct", o_a_funct, q_fn[eid]);
            chk("exec_a_src", o_a_alu_src, q_src[eid]);
            chk("exec_a_pc", o_a_pc, q_pc[eid]);
            chk("exec_ready", {o_r0_ready, o_r1_ready}, 0);
            chk("exec_rsp_valid", o_rsp_valid, 0);
            i_alu_done  = (c == d);
            i_alu_value = aval;
            i_alu_pc    = apc;
            @(posedge i_clk);
            if (c == d) break;
        end
        @(negedge i_clk);
        i_alu_done  = 1'b0;
        i_alu_value = $urandom;
        i_alu_pc    = $urandom;
        #1;
        chk("rsp_valid", o_rsp_valid, 1);
        chk("rsp_id", o_rsp_id, eid);
        chk("rsp_value", o_rsp_value, evl);
        chk("rsp_pc", o_rsp_pc, epc);
        chk("rsp_err", o_rsp_err, eerr);
        chk("rsp_a_rs_zero", o_a_rs, 0);
        chk("rsp_ready", {o_r0_ready, o_r1_ready}, 0);
        repeat (w) begin
            @(posedge i_clk);
            @(negedge i_clk);
            chk("stall_rsp_valid", o_rsp_valid, 1);
            chk("stall_rsp_id", o_rsp_id, eid);
            chk("stall_rsp_value", o_rsp_value, evl);
            chk("stall_rsp_pc", o_rsp_pc, epc);
            chk("stall_rsp_err", o_rsp_err, eerr);
            chk("stall_ready", {o_r0_ready, o_r1_ready}, 0);
        end
        i_rsp_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_rsp_ready = 1'b0;
        chk("post_hs_rsp_valid", o_rsp_valid, 0);
        model_rr = ~eid;
    endtask

    typedef struct {
        logic        v0, v1;
        logic [31:0] rs0, rt0, rs1;
        logic [15:0] imm1;
        logic        src1;
        int          d, w;
        logic [31:0] aval, apc;
        logic        eid, eerr;
        logic [31:0] evl, epc;
    } vec_t;

    vec_t tbl [9];

    initial begin
        logic eid;
        logic [31:0] aval, apc;
        int d, w, r;

        //            v0 v1 rs0 rt0 rs1 imm1 src1 d w aval      apc       id err val  pc
        tbl[0] = '{1, 1, 5, 4, 7, 10, 1, 1, 0, 9,        32'h100,  0, 0, 9,   32'h100};
        tbl[1] = '{1, 1, 5, 4, 7, 10, 1, 1, 0, 17,       32'h200,  1, 0, 17,  32'h200};
        tbl[2] = '{1, 1, 5, 4, 7, 10, 1, 2, 0, 3,        4,        0, 0, 3,   4};
        tbl[3] = '{1, 1, 5, 4, 7, 10, 1, 3, 0, 5,        6,        1, 0, 5,   6};
        tbl[4] = '{1, 0, 5, 4, 7, 10, 1, 1, 0, 9,        32'h10,   0, 0, 9,   32'h10};
        tbl[5] = '{0, 1, 5, 4, 7, 10, 1, 4, 0, 32'hAA,   32'hBB,   1, 0, 32'hAA, 32'hBB};
        tbl[6] = '{1, 0, 5, 4, 7, 10, 1, 5, 0, 32'hDEAD, 32'hBEEF, 0, 1, 0,   0};
        tbl[7] = '{1, 0, 5, 4, 7, 10, 1, 2, 3, 42,       44,       0, 0, 42,  44};
        tbl[8] = '{1, 1, 5, 4, 7, 10, 1, 1, 0, 1,        2,        1, 0, 1,   2};

        i_rst = 1'b0;
        i_r0_valid = 1'b1; i_r1_valid = 1'b1;
        i_alu_value = '0; i_alu_pc = '0; i_alu_done = 1'b0; i_rsp_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            q_rs[k] = '0; q_rt[k] = '0; q_imm[k] = '0; q_fn[k] = '0; q_src[k] = 1'b0; q_pc[k] = '0;
        end
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk_idle_outputs("reset");
        i_r0_valid = 1'b0; i_r1_valid = 1'b0;
        i_rst = 1'b1;

        // Directed table.
        for (int i = 0; i < 9; i++) begin
            q_rs[0] = tbl[i].rs0; q_rt[0] = tbl[i].rt0; q_imm[0] = 16'h0033;
            q_fn[0] = 5'd0; q_src[0] = 1'b0; q_pc[0] = 32'h1000;
            q_rs[1] = tbl[i].rs1; q_rt[1] = 32'h0; q_imm[1] = tbl[i].imm1;
            q_fn[1] = 5'd3; q_src[1] = tbl[i].src1; q_pc[1] = 32'h2000;
            do_op(tbl[i].v0, tbl[i].v1, tbl[i].d, tbl[i].w, tbl[i].aval, tbl[i].apc,
                  tbl[i].eid, tbl[i].eerr, tbl[i].evl, tbl[i].epc);
        end

        // Reset in the middle of an execute owned by req 1: op is dropped, pointer back to req 0.
        @(negedge i_clk);
        i_r0_valid = 1'b0; i_r1_valid = 1'b1;
        @(negedge i_clk);
        chk("abort_a_rs_before", o_a_rs, q_rs[1]);
        i_rst = 1'b0;
        #1;
        chk_idle_outputs("abort");
        @(negedge i_clk);
        chk_idle_outputs("abort_hold");
        i_r1_valid = 1'b0;
        i_rst = 1'b1;
        model_rr = 1'b0;
        @(negedge i_clk);
        chk("abort_no_rsp", o_rsp_valid, 0);
        do_op(1'b1, 1'b1, 1, 0, 32'h77, 32'h78, 1'b0, 1'b0, 32'h77, 32'h78);

        // Randomised transactions against a transaction-level model.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge i_clk);
                i_r0_valid = 1'b0; i_r1_valid = 1'b0;
                #1;
                chk("rand_idle_ready", {o_r0_ready, o_r1_ready}, 0);
            end
            for (int k = 0; k < 2; k++) begin
                q_rs[k] = $urandom; q_rt[k] = $urandom; q_imm[k] = 16'($urandom);
                q_fn[k] = 5'($urandom); q_src[k] = 1'($urandom); q_pc[k] = $urandom;
            end
            r    = $urandom_range(1, 3);
            d    = $urandom_range(1, MAX_WAIT + 1);
            w    = $urandom_range(0, 2);
            aval = $urandom;
            apc  = $urandom;
            if (r == 3) eid = model_rr;
            else        eid = (r == 2);
            do_op(r[0], r[1], d, w, aval, apc, eid, d > MAX_WAIT,
                  (d > MAX_WAIT) ? 32'h0 : aval, (d > MAX_WAIT) ? 32'h0 : apc);
        end

        i_r0_valid = 1'b0; i_r1_valid = 1'b0;
        repeat (2) @(posedge i_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
